// File: rtl/csr_rmw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : csr_rmw_arbiter
// Brief    : Round-robin read-modify-write sequencer sharing one CSR read/write
//            port pair between the core CSR path and a host/debug port.
//            Optional read-only space check: define CSR_RMW_RO_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module csr_rmw_arbiter #(
    parameter int CSR_ADDR_BITS = 12,
    parameter int NW_BITS       = 2,
    parameter int UUID_BITS     = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_req_valid,
    output logic                     core_req_ready,
    input  logic [1:0]               core_req_op,
    input  logic [CSR_ADDR_BITS-1:0] core_req_addr,
    input  logic [NW_BITS-1:0]       core_req_wid,
    input  logic [UUID_BITS-1:0]     core_req_uuid,
    input  logic [31:0]              core_req_data,
    output logic                     core_rsp_valid,
    input  logic                     core_rsp_ready,
    output logic [31:0]              core_rsp_data,
    output logic                     core_rsp_err,
    input  logic                     host_req_valid,
    output logic                     host_req_ready,
    input  logic [1:0]               host_req_op,
    input  logic [CSR_ADDR_BITS-1:0] host_req_addr,
    input  logic [NW_BITS-1:0]       host_req_wid,
    input  logic [UUID_BITS-1:0]     host_req_uuid,
    input  logic [31:0]              host_req_data,
    output logic                     host_rsp_valid,
    input  logic                     host_rsp_ready,
    output logic [31:0]              host_rsp_data,
    output logic                     host_rsp_err,
    output logic                     read_enable,
    output logic [CSR_ADDR_BITS-1:0] read_addr,
    output logic [NW_BITS-1:0]       read_wid,
    output logic [UUID_BITS-1:0]     read_uuid,
    input  logic [31:0]              read_data,
    output logic                     write_enable,
    output logic [CSR_ADDR_BITS-1:0] write_addr,
    output logic [NW_BITS-1:0]       write_wid,
    output logic [UUID_BITS-1:0]     write_uuid,
    output logic [31:0]              write_data,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] c_OP_RW = 2'd1;
    localparam logic [1:0] c_OP_RS = 2'd2;
    localparam logic [1:0] c_OP_RC = 2'd3;

    state_t r_state;
    state_t w_state_next;

    logic                     r_rr_ptr;
    logic                     r_src;
    logic [1:0]               r_op;
    logic [CSR_ADDR_BITS-1:0] r_addr;
    logic [NW_BITS-1:0]       r_wid;
    logic [UUID_BITS-1:0]     r_uuid;
    logic [31:0]              r_data;
    logic [31:0]              r_old;
    logic [31:0]              r_new;
    logic                     r_do_write;
    logic                     r_err;

    logic        w_in_idle;
    logic        w_accept;
    logic        w_rsp_fire;
    logic [31:0] w_new;
    logic        w_do_write;
    logic        w_ro_err;

    // Ready is masked by reset so nothing is granted while reset is held.
    assign w_in_idle      = (r_state == ST_IDLE) && !reset;
    assign core_req_ready = w_in_idle && core_req_valid && (!host_req_valid || !r_rr_ptr);
    assign host_req_ready = w_in_idle && host_req_valid && (!core_req_valid || r_rr_ptr);
    assign w_accept       = core_req_ready || host_req_ready;
    assign w_rsp_fire     = (r_state == ST_RESP) && (r_src ? host_rsp_ready : core_rsp_ready);
    assign busy           = (r_state != ST_IDLE);

    always_comb begin
        w_new      = read_data;
        w_do_write = 1'b0;
        case (r_op)
            c_OP_RW: begin
                w_new      = r_data;
                w_do_write = 1'b1;
            end
            c_OP_RS: begin
                w_new      = read_data | r_data;
                w_do_write = |r_data;
            end
            c_OP_RC: begin
                w_new      = read_data & ~r_data;
                w_do_write = |r_data;
            end
            default: begin
                w_new      = read_data;
                w_do_write = 1'b0;
            end
        endcase
    end

`ifdef CSR_RMW_RO_CHECK_EN
    assign w_ro_err = w_do_write && (r_addr[11:10] == 2'b11);
`else
    assign w_ro_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        read_enable    = 1'b0;
        read_addr      = '0;
        read_wid       = '0;
        read_uuid      = '0;
        write_enable   = 1'b0;
        write_addr     = '0;
        write_wid      = '0;
        write_uuid     = '0;
        write_data     = '0;
        core_rsp_valid = 1'b0;
        core_rsp_data  = '0;
        core_rsp_err   = 1'b0;
        host_rsp_valid = 1'b0;
        host_rsp_data  = '0;
        host_rsp_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_READ;
            end
            ST_READ: begin
                read_enable  = 1'b1;
                read_addr    = r_addr;
                read_wid     = r_wid;
                read_uuid    = r_uuid;
                w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (r_do_write) begin
                    write_enable = 1'b1;
                    write_addr   = r_addr;
                    write_wid    = r_wid;
                    write_uuid   = r_uuid;
                    write_data   = r_new;
                end
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (r_src) begin
                    host_rsp_valid = 1'b1;
                    host_rsp_data  = r_old;
                    host_rsp_err   = r_err;
                end else begin
                    core_rsp_valid = 1'b1;
                    core_rsp_data  = r_old;
                    core_rsp_err   = r_err;
                end
                if (w_rsp_fire) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= 1'b0;
            r_src      <= 1'b0;
            r_op       <= '0;
            r_addr     <= '0;
            r_wid      <= '0;
            r_uuid     <= '0;
            r_data     <= '0;
            r_old      <= '0;
            r_new      <= '0;
            r_do_write <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_src    <= host_req_ready;
                r_rr_ptr <= !host_req_ready;
                r_op     <= host_req_ready ? host_req_op   : core_req_op;
                r_addr   <= host_req_ready ? host_req_addr : core_req_addr;
                r_wid    <= host_req_ready ? host_req_wid  : core_req_wid;
                r_uuid   <= host_req_ready ? host_req_uuid : core_req_uuid;
                r_data   <= host_req_ready ? host_req_data : core_req_data;
            end
            // A flagged read-only violation suppresses the write but keeps old data.
            if (r_state == ST_READ) begin
                r_old      <= read_data;
                r_new      <= w_new;
                r_do_write <= w_do_write && !w_ro_err;
                r_err      <= w_ro_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_rmw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_rmw_arbiter
// Brief    : Directed self-checking bench for csr_rmw_arbiter with a CSR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_rmw_arbiter;

`ifdef CSR_RMW_RO_CHECK_EN
    localparam bit c_RO_EN = 1'b1;
`else
    localparam bit c_RO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req_valid, core_req_ready, core_rsp_valid, core_rsp_ready, core_rsp_err;
    logic [1:0]  core_req_op;
    logic [11:0] core_req_addr;
    logic [1:0]  core_req_wid;
    logic [43:0] core_req_uuid;
    logic [31:0] core_req_data, core_rsp_data;
    logic        host_req_valid, host_req_ready, host_rsp_valid, host_rsp_ready, host_rsp_err;
    logic [1:0]  host_req_op;
    logic [11:0] host_req_addr;
    logic [1:0]  host_req_wid;
    logic [43:0] host_req_uuid;
    logic [31:0] host_req_data, host_rsp_data;
    logic        read_enable, write_enable, busy;
    logic [11:0] read_addr, write_addr;
    logic [1:0]  read_wid, write_wid;
    logic [43:0] read_uuid, write_uuid;
    logic [31:0] read_data, write_data;

    logic [31:0] mem [0:4095];
    logic        load_en;
    logic [11:0] load_addr;
    logic [31:0] load_data;

    int n_checks = 0;
    int n_errors = 0;

    csr_rmw_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_op(core_req_op), .core_req_addr(core_req_addr),
        .core_req_wid(core_req_wid), .core_req_uuid(core_req_uuid),
        .core_req_data(core_req_data), .core_rsp_valid(core_rsp_valid),
        .core_rsp_ready(core_rsp_ready), .core_rsp_data(core_rsp_data),
        .core_rsp_err(core_rsp_err),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_op(host_req_op), .host_req_addr(host_req_addr),
        .host_req_wid(host_req_wid), .host_req_uuid(host_req_uuid),
        .host_req_data(host_req_data), .host_rsp_valid(host_rsp_valid),
        .host_rsp_ready(host_rsp_ready), .host_rsp_data(host_rsp_data),
        .host_rsp_err(host_rsp_err),
        .read_enable(read_enable), .read_addr(read_addr), .read_wid(read_wid),
        .read_uuid(read_uuid), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_wid(write_wid),
        .write_uuid(write_uuid), .write_data(write_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign read_data = mem[read_addr];

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (write_enable) mem[write_addr] <= write_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic set_req(input bit host, input bit v, input logic [1:0] op,
                           input logic [11:0] addr, input logic [31:0] data);
        if (host) begin
            host_req_valid = v; host_req_op = op; host_req_addr = addr;
            host_req_data = data; host_req_wid = 2'd2; host_req_uuid = {32'h000B0057, addr};
        end else begin
            core_req_valid = v; core_req_op = op; core_req_addr = addr;
            core_req_data = data; core_req_wid = 2'd1; core_req_uuid = {32'h0000C0DE, addr};
        end
    endtask

    // One full transaction for a single requester; ready is expected at once.
    task automatic run_txn(input bit host, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_old,
                           input bit exp_we, input logic [31:0] exp_new, input bit exp_err);
        int k;
        @(negedge clk);
        set_req(host, 1'b1, op, addr, data);
        core_rsp_ready = 1'b0; host_rsp_ready = 1'b0;
        #1;
        k = 0;
        while (!(host ? host_req_ready : core_req_ready) && k < 20) begin
            @(negedge clk); #1; k++;
        end
        check("req_wait", k, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(host, 1'b0, op, addr, data);
        check("rd_en", read_enable, 1);
        check("rd_addr", read_addr, addr);
        check("rd_wid", read_wid, host ? 2'd2 : 2'd1);
        check("rd_uuid", read_uuid, {(host ? 32'h000B0057 : 32'h0000C0DE), addr});
        @(negedge clk);
        check("wr_en", write_enable, exp_we);
        if (exp_we) begin
            check("wr_data", write_data, exp_new);
            check("wr_addr", write_addr, addr);
        end else begin
            check("wr_data_idle", write_data, 0);
        end
        @(negedge clk);
        check("rsp_valid", host ? host_rsp_valid : core_rsp_valid, 1);
        check("rsp_data", host ? host_rsp_data : core_rsp_data, exp_old);
        check("rsp_err", host ? host_rsp_err : core_rsp_err, exp_err);
        check("other_rsp_valid", host ? core_rsp_valid : host_rsp_valid, 0);
        if (host) host_rsp_ready = 1'b1; else core_rsp_ready = 1'b1;
        @(negedge clk);
        core_rsp_ready = 1'b0; host_rsp_ready = 1'b0;
        check("busy_after", busy, 0);
        check("rsp_valid_after", host ? host_rsp_valid : core_rsp_valid, 0);
    endtask

    initial begin
        int n;
        int cyc;
        bit grant [0:3];
        int gcyc [0:3];

        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        core_rsp_ready = 1'b0; host_rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, 2'd0, 12'h0, 32'h0);
        set_req(1'b1, 1'b0, 2'd0, 12'h0, 32'h0);

        // Reset with a core request pending
        load(12'h300, 32'h8);
        @(negedge clk);
        set_req(1'b0, 1'b1, 2'd1, 12'h300, 32'h1888);
        #1;
        check("rst_core_ready", core_req_ready, 0);
        check("rst_host_ready", host_req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_en", read_enable, 0);
        check("rst_rd_addr", read_addr, 0);
        check("rst_wr_en", write_enable, 0);
        check("rst_core_rsp_valid", core_rsp_valid, 0);
        check("rst_core_rsp_data", core_rsp_data, 0);
        check("rst_core_rsp_err", core_rsp_err, 0);
        check("rst_host_rsp_valid", host_rsp_valid, 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Core RW 0x300: old 0x8, new 0x1888
        run_txn(1'b0, 2'd1, 12'h300, 32'h1888, 32'h8, 1'b1, 32'h1888, 1'b0);
        check("mem_300_rw", mem[12'h300], 32'h1888);

        // Host RS zero mask, then RC 0x5, then core RS 0xF00
        load(12'h300, 32'h55);
        run_txn(1'b1, 2'd2, 12'h300, 32'h0, 32'h55, 1'b0, 32'h0, 1'b0);
        run_txn(1'b1, 2'd3, 12'h300, 32'h5, 32'h55, 1'b1, 32'h50, 1'b0);
        run_txn(1'b0, 2'd2, 12'h300, 32'hF00, 32'h50, 1'b1, 32'hF50, 1'b0);
        run_txn(1'b1, 2'd0, 12'h300, 32'hFFFF, 32'hF50, 1'b0, 32'h0, 1'b0);

        // Both requesters valid continuously: strict alternation, 4-cycle spacing
        @(negedge clk);
        set_req(1'b0, 1'b1, 2'd0, 12'h010, 32'h0);
        set_req(1'b1, 1'b1, 2'd0, 12'h020, 32'h0);
        core_rsp_ready = 1'b1; host_rsp_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 60) begin
            #1;
            if (core_req_ready || host_req_ready) begin
                grant[n] = host_req_ready;
                gcyc[n] = cyc;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        set_req(1'b0, 1'b0, 2'd0, 12'h010, 32'h0);
        set_req(1'b1, 1'b0, 2'd0, 12'h020, 32'h0);
        check("rr_count", n, 4);
        check("rr_grant0", grant[0], 0);
        check("rr_grant1", grant[1], 1);
        check("rr_grant2", grant[2], 0);
        check("rr_grant3", grant[3], 1);
        for (int i = 1; i < 4; i++) check("rr_interval", gcyc[i] - gcyc[i-1], 4);
        cyc = 0;
        while (busy && cyc < 10) begin @(negedge clk); cyc++; end
        check("rr_drain", busy, 0);
        core_rsp_ready = 1'b0; host_rsp_ready = 1'b0;

        // Core response stall with host waiting
        load(12'h040, 32'h1234);
        @(negedge clk);
        set_req(1'b0, 1'b1, 2'd1, 12'h040, 32'hA5A5);
        set_req(1'b1, 1'b1, 2'd0, 12'h040, 32'h0);
        host_rsp_ready = 1'b1;
        #1;
        check("stall_core_ready", core_req_ready, 1);
        check("stall_host_ready", host_req_ready, 0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd1, 12'h040, 32'hA5A5);
        @(negedge clk);
        check("stall_wr_data", write_data, 32'hA5A5);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", core_rsp_valid, 1);
            check("stall_rsp_data", core_rsp_data, 32'h1234);
            check("stall_host_held", host_req_ready, 0);
            @(negedge clk);
        end
        core_rsp_ready = 1'b1;
        @(negedge clk);
        core_rsp_ready = 1'b0;
        #1;
        check("stall_rsp_done", core_rsp_valid, 0);
        check("stall_host_now", host_req_ready, 1);
        @(negedge clk);
        set_req(1'b1, 1'b0, 2'd0, 12'h040, 32'h0);
        check("host_rd_en", read_enable, 1);
        @(negedge clk);
        @(negedge clk);
        check("host_rsp_valid", host_rsp_valid, 1);
        check("host_rsp_data", host_rsp_data, 32'hA5A5);
        @(negedge clk);
        check("host_busy_after", busy, 0);
        host_rsp_ready = 1'b0;

        // Read-only space: RW faults when checking is built in; reads and zero masks are legal
        load(12'hC00, 32'h77);
        run_txn(1'b0, 2'd1, 12'hC00, 32'hFF, 32'h77, !c_RO_EN, 32'hFF, c_RO_EN);
        run_txn(1'b0, 2'd2, 12'hC00, 32'h0, c_RO_EN ? 32'h77 : 32'hFF, 1'b0, 32'h0, 1'b0);
        run_txn(1'b1, 2'd0, 12'hC00, 32'h0, c_RO_EN ? 32'h77 : 32'hFF, 1'b0, 32'h0, 1'b0);

        // Reset in the middle of a transaction drops it without a write
        load(12'h050, 32'h11);
        @(negedge clk);
        set_req(1'b0, 1'b1, 2'd1, 12'h050, 32'h99);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd1, 12'h050, 32'h99);
        check("mid_rd_en", read_enable, 1);
        reset = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_rd_en_rst", read_enable, 0);
        @(negedge clk);
        check("mid_wr_en", write_enable, 0);
        check("mid_rsp_valid", core_rsp_valid, 0);
        reset = 1'b0;
        run_txn(1'b0, 2'd0, 12'h050, 32'h0, 32'h11, 1'b0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
